// File: rtl/vga_char_scanner_if.sv
// Read bus from the VGA scanner into the character buffer.
// Address leaves combinationally; lit comes back one cycle later.
interface vga_char_scanner_if;
  logic [6:0] hchar;
  logic [5:0] vchar;
  logic [2:0] hoffset;
  logic [2:0] voffset;
  logic       lit;

  modport master (
    output hchar,
    output vchar,
    output hoffset,
    output voffset,
    input  lit
  );

  modport slave (
    input  hchar,
    input  vchar,
    input  hoffset,
    input  voffset,
    output lit
  );
endinterface

// File: rtl/vga_char_scanner.sv
// VGA raster scanner: 8x8 cell addressing out, lit pixel in,
// sync and colour realigned through a two-stage pipeline.
module vga_char_scanner #(
  parameter int          H_VISIBLE = 640,
  parameter int          H_FRONT   = 16,
  parameter int          H_SYNC    = 96,
  parameter int          H_BACK    = 48,
  parameter int          V_VISIBLE = 480,
  parameter int          V_FRONT   = 10,
  parameter int          V_SYNC    = 2,
  parameter int          V_BACK    = 33,
  parameter logic [11:0] FG_COLOR  = 12'hFFF,
  parameter logic [11:0] BG_COLOR  = 12'h000
) (
  input  logic               clk,
  input  logic               rst,
  vga_char_scanner_if.master read,
  output logic               vga_hsync,
  output logic               vga_vsync,
  output logic [3:0]         vga_r,
  output logic [3:0]         vga_g,
  output logic [3:0]         vga_b,
  output logic               frame_start
);

  localparam int H_TOTAL =
    H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL =
    V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] H_SS   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_SE   =
    10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);

  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] V_SS   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_SE   =
    10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic        h_last;
  logic        v_last;
  logic        frame_seen;

  logic        active;
  logic        hs;
  logic        vs;
  logic        origin;

  logic        active_d1;
  logic        hs_d1;
  logic        vs_d1;
  logic        origin_d1;

  logic [11:0] rgb;

  assign h_last = (h_cnt == H_LAST);
  assign v_last = (v_cnt == V_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt      <= '0;
      v_cnt      <= '0;
      frame_seen <= 1'b0;
    end else if (h_last) begin
      h_cnt <= '0;
      if (v_last) begin
        v_cnt      <= '0;
        frame_seen <= 1'b1;
      end else begin
        v_cnt <= v_cnt + 10'd1;
      end
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  // origin only counts once a full frame has wrapped
  always_comb begin
    active = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    hs     = !((h_cnt >= H_SS) && (h_cnt < H_SE));
    vs     = !((v_cnt >= V_SS) && (v_cnt < V_SE));
    origin = (h_cnt == '0) && (v_cnt == '0)
             && frame_seen;
  end

  always_comb begin
    read.hchar   = '1;
    read.vchar   = '1;
    read.hoffset = '1;
    read.voffset = '1;
    if (active) begin
      read.hchar   = h_cnt[9:3];
      read.hoffset = h_cnt[2:0];
      read.vchar   = v_cnt[8:3];
      read.voffset = v_cnt[2:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_d1 <= 1'b0;
      hs_d1     <= 1'b1;
      vs_d1     <= 1'b1;
      origin_d1 <= 1'b0;
    end else begin
      active_d1 <= active;
      hs_d1     <= hs;
      vs_d1     <= vs;
      origin_d1 <= origin;
    end
  end

  // lit is only meaningful for visible pixels
  always_ff @(posedge clk) begin
    if (rst) begin
      vga_hsync   <= 1'b1;
      vga_vsync   <= 1'b1;
      rgb         <= '0;
      frame_start <= 1'b0;
    end else begin
      vga_hsync   <= hs_d1;
      vga_vsync   <= vs_d1;
      frame_start <= origin_d1;
      if (!active_d1) begin
        rgb <= '0;
      end else if (read.lit) begin
        rgb <= FG_COLOR;
      end else begin
        rgb <= BG_COLOR;
      end
    end
  end

  assign vga_r = rgb[11:8];
  assign vga_g = rgb[7:4];
  assign vga_b = rgb[3:0];

endmodule

// File: tb/tb_vga_char_scanner.sv
// Bench for vga_char_scanner on a shrunken raster with
// a lookup-table buffer model and arithmetic reference.
module tb_vga_char_scanner;

  localparam int HV = 64;
  localparam int HF = 4;
  localparam int HS = 8;
  localparam int HB = 4;
  localparam int HT = HV + HF + HS + HB;
  localparam int VV = 48;
  localparam int VF = 2;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam logic [11:0] FG = 12'hA5C;
  localparam logic [11:0] BG = 12'h31E;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vga_hsync;
  logic       vga_vsync;
  logic [3:0] vga_r;
  logic [3:0] vga_g;
  logic [3:0] vga_b;
  logic       frame_start;

  vga_char_scanner_if bus ();

  vga_char_scanner #(
    .H_VISIBLE (HV),
    .H_FRONT   (HF),
    .H_SYNC    (HS),
    .H_BACK    (HB),
    .V_VISIBLE (VV),
    .V_FRONT   (VF),
    .V_SYNC    (VS),
    .V_BACK    (VB),
    .FG_COLOR  (FG),
    .BG_COLOR  (BG)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .read        (bus),
    .vga_hsync   (vga_hsync),
    .vga_vsync   (vga_vsync),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  bit lit_map [HV][VV];
  bit blank_one;

  int n;
  int total;
  int bad;
  int hs_fall, hs_rise, vs_fall, vs_rise;
  int fs_cnt, fs_at;
  logic prev_hs, prev_vs;

  // character buffer: pixel table, garbage when out of range
  always @(posedge clk) begin : buffer_model
    int x;
    int y;
    x = int'({bus.hchar, bus.hoffset});
    y = int'({bus.vchar, bus.voffset});
    if (x < HV && y < VV)
      bus.lit <= lit_map[x][y];
    else if (blank_one)
      bus.lit <= 1'b1;
    else
      bus.lit <= 1'($urandom_range(0, 1));
  end

  function automatic logic [18:0] exp_addr(int p);
    int x;
    int y;
    x = p % HT;
    y = (p / HT) % VT;
    if (x < HV && y < VV)
      return {7'(x / 8), 6'(y / 8), 3'(x % 8), 3'(y % 8)};
    return '1;
  endfunction

  // {hsync, vsync, rgb, frame_start} for pixel index p
  function automatic logic [14:0] exp_pins(int p);
    int x;
    int y;
    int f;
    logic hs;
    logic vs;
    logic [11:0] c;
    if (p < 0) return {1'b1, 1'b1, 12'h000, 1'b0};
    x = p % HT;
    y = (p / HT) % VT;
    f = p / FRAME;
    hs = !(x >= HV + HF && x < HV + HF + HS);
    vs = !(y >= VV + VF && y < VV + VF + VS);
    c = 12'h000;
    if (x < HV && y < VV) c = lit_map[x][y] ? FG : BG;
    return {hs, vs, c, (x == 0 && y == 0 && f >= 1)};
  endfunction

  function automatic logic [18:0] act_addr();
    return {bus.hchar, bus.vchar, bus.hoffset, bus.voffset};
  endfunction

  function automatic logic [14:0] act_pins();
    return {vga_hsync, vga_vsync, vga_r, vga_g, vga_b,
            frame_start};
  endfunction

  task automatic cmp(input string name,
                     input logic [31:0] act,
                     input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s n=%0d got=%h want=%h",
               name, n, act, want);
    end
  endtask

  task automatic clear_track();
    hs_fall = -1;
    hs_rise = -1;
    vs_fall = -1;
    vs_rise = -1;
    fs_cnt  = 0;
    fs_at   = -1;
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) n = 0;
    else n++;
    @(negedge clk);
    cmp("addr", 32'(act_addr()), 32'(exp_addr(n)));
    cmp("pins", 32'(act_pins()), 32'(exp_pins(n - 2)));
    if (prev_hs && !vga_hsync && hs_fall < 0) hs_fall = n;
    if (!prev_hs && vga_hsync && hs_fall >= 0 && hs_rise < 0)
      hs_rise = n;
    if (prev_vs && !vga_vsync && vs_fall < 0) vs_fall = n;
    if (!prev_vs && vga_vsync && vs_fall >= 0 && vs_rise < 0)
      vs_rise = n;
    if (frame_start) begin
      fs_cnt++;
      fs_at = n;
    end
    prev_hs = vga_hsync;
    prev_vs = vga_vsync;
  endtask

  task automatic run_to(int target);
    while (n < target) step();
  endtask

  task automatic do_reset(int cyc);
    rst = 1'b1;
    repeat (cyc) step();
    rst = 1'b0;
    clear_track();
  endtask

  typedef struct {
    int          x;
    int          y;
    logic [18:0] addr;
  } vec_t;

  vec_t vecs [10];
  int   target;

  initial begin
    total = 0;
    bad = 0;
    n = 0;
    prev_hs = 1'b1;
    prev_vs = 1'b1;
    clear_track();

    vecs[0] = '{0,  0,  {7'd0, 6'd0, 3'd0, 3'd0}};
    vecs[1] = '{5,  0,  {7'd0, 6'd0, 3'd5, 3'd0}};
    vecs[2] = '{63, 0,  {7'd7, 6'd0, 3'd7, 3'd0}};
    vecs[3] = '{64, 0,  19'h7FFFF};
    vecs[4] = '{79, 0,  19'h7FFFF};
    vecs[5] = '{0,  8,  {7'd0, 6'd1, 3'd0, 3'd0}};
    vecs[6] = '{27, 10, {7'd3, 6'd1, 3'd3, 3'd2}};
    vecs[7] = '{63, 47, {7'd7, 6'd5, 3'd7, 3'd7}};
    vecs[8] = '{0,  48, 19'h7FFFF};
    vecs[9] = '{79, 54, 19'h7FFFF};

    // pattern: column cell 3, row offset 2
    blank_one = 1'b0;
    for (int x = 0; x < HV; x++)
      for (int y = 0; y < VV; y++)
        lit_map[x][y] = (x / 8 == 3) && (y % 8 == 2);

    do_reset(5);
    cmp("rst_hsync", 32'(vga_hsync), 32'd1);
    cmp("rst_vsync", 32'(vga_vsync), 32'd1);
    cmp("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
    cmp("rst_fs", 32'(frame_start), 32'd0);
    cmp("rst_addr", 32'(act_addr()), 32'd0);

    for (int i = 0; i < 10; i++) begin
      run_to(vecs[i].y * HT + vecs[i].x);
      cmp("vec_addr", 32'(act_addr()), 32'(vecs[i].addr));
    end
    run_to(FRAME + 10);
    cmp("hs_fall", 32'(hs_fall), 32'(HV + HF + 2));
    cmp("hs_width", 32'(hs_rise - hs_fall), 32'(HS));
    cmp("vs_fall", 32'(vs_fall), 32'((VV + VF) * HT + 2));
    cmp("vs_width", 32'(vs_rise - vs_fall), 32'(VS * HT));
    cmp("fs_count", 32'(fs_cnt), 32'd1);
    cmp("fs_pos", 32'(fs_at), 32'(FRAME + 2));

    // constant lit everywhere, blanking must still be black
    blank_one = 1'b1;
    for (int x = 0; x < HV; x++)
      for (int y = 0; y < VV; y++)
        lit_map[x][y] = 1'b1;
    do_reset(2);
    run_to(FRAME + 5);

    // random image, mid-frame reset
    blank_one = 1'b0;
    for (int x = 0; x < HV; x++)
      for (int y = 0; y < VV; y++)
        lit_map[x][y] = 1'($urandom_range(0, 1));
    do_reset(3);
    run_to(20 * HT + 30);
    rst = 1'b1;
    step();
    cmp("midrst_pins", 32'(act_pins()), 32'h6000);
    cmp("midrst_addr", 32'(act_addr()), 32'd0);
    rst = 1'b0;
    clear_track();
    run_to(FRAME + 10);
    cmp("fs2_count", 32'(fs_cnt), 32'd1);
    cmp("fs2_pos", 32'(fs_at), 32'(FRAME + 2));

    // reset at a random point of random length
    target = $urandom_range(100, FRAME - 100);
    run_to(target);
    do_reset($urandom_range(1, 3));
    run_to(2 * HT + 20);
    cmp("fs3_none", 32'(fs_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
